// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: drives word fetches from a 22-bit pc into the IF/ID register,
// with a one-entry skid buffer for decode stalls, branch redirect and halt.
module instr_fetch_stage #(
    parameter logic [21:0] RESET_PC  = 22'h000000,
    parameter logic [31:0] NOP_INSTR = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [21:0] imem_addr,
    output logic        imem_re,
    input  logic        imem_rdy,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [21:0] branch_addr,
    input  logic        hlt,
    output logic [31:0] instr_ID,
    output logic [21:0] PC_ID,
    output logic        valid_ID
);

    typedef enum logic [1:0] {StFetch, StHold, StHalt} state_e;

    state_e      state_q, state_d;
    logic [21:0] pc_q, pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [21:0] buf_pc_q, buf_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic [21:0] pc_id_q, pc_id_d;
    logic        valid_id_q, valid_id_d;

    logic redirect, halt_req, fetch_ok;

    // Branch and halt are ignored once halted; only reset leaves StHalt.
    assign redirect = branch_taken && (state_q != StHalt);
    assign halt_req = hlt && !branch_taken && (state_q != StHalt);
    assign fetch_ok = (state_q == StFetch) && imem_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = StFetch;
        end else if (halt_req) begin
            state_d = StHalt;
        end else begin
            unique case (state_q)
                StFetch: if (stall && imem_rdy) state_d = StHold;
                StHold:  if (!stall) state_d = StFetch;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        imem_re   = rst_n && (state_q == StFetch);
        imem_addr = pc_q;
        instr_ID  = instr_id_q;
        PC_ID     = pc_id_q;
        valid_ID  = valid_id_q;
    end

    always_comb begin
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;
        instr_id_d  = instr_id_q;
        pc_id_d     = pc_id_q;
        valid_id_d  = valid_id_q;
        if (redirect || halt_req) begin
            if (redirect) pc_d = branch_addr;
            buf_valid_d = 1'b0;
            instr_id_d  = NOP_INSTR;
            valid_id_d  = 1'b0;
        end else if (state_q == StHold) begin
            if (!stall) begin
                instr_id_d  = buf_instr_q;
                pc_id_d     = buf_pc_q;
                valid_id_d  = 1'b1;
                buf_valid_d = 1'b0;
            end
        end else if (state_q == StFetch) begin
            if (stall) begin
                if (imem_rdy) begin
                    buf_instr_d = imem_data;
                    buf_pc_d    = pc_q;
                    buf_valid_d = 1'b1;
                end
            end else if (fetch_ok) begin
                instr_id_d = imem_data;
                pc_id_d    = pc_q;
                valid_id_d = 1'b1;
            end else begin
                instr_id_d = NOP_INSTR;
                valid_id_d = 1'b0;
            end
            // Natural 22-bit wrap of the increment.
            if (fetch_ok) pc_d = pc_q + 22'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            buf_instr_q <= 32'h0;
            buf_pc_q    <= 22'h0;
            buf_valid_q <= 1'b0;
            instr_id_q  <= NOP_INSTR;
            pc_id_q     <= 22'h0;
            valid_id_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
            instr_id_q  <= instr_id_d;
            pc_id_q     <= pc_id_d;
            valid_id_q  <= valid_id_d;
        end
    end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 22'h000000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h3000_0000 (MOV r0,r0), bubble encoding driven to decode.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-005 imem_addr  output  22  word address of the current fetch request.
REQ-006 imem_re  output  1  fetch request; imem_addr is valid while high.
REQ-007 imem_rdy  input  1  imem_data holds the word at the current imem_addr this cycle.
REQ-008 imem_data  input  32  instruction word, qualified by imem_rdy.
REQ-009 stall  input  1  decode cannot accept a new instruction; hold IF/ID outputs.
REQ-010 branch_taken  input  1  redirect request from branch resolution.
REQ-011 branch_addr  input  22  redirect target, qualified by branch_taken.
REQ-012 hlt  input  1  HALT decoded in ID; stop fetching.
REQ-013 instr_ID  output  32  registered instruction to decode.
REQ-014 PC_ID  output  22  registered address of instr_ID.
REQ-015 valid_ID  output  1  registered; high when instr_ID is a real fetched instruction.

Function
REQ-016 SHALL hold a 22-bit pc register, a one-entry skid buffer (32-bit word, 22-bit address, valid bit), and an FSM with states FETCH, HOLD, HALT.
REQ-017 imem_addr SHALL equal pc combinationally; imem_re SHALL be 1 only in FETCH with rst_n high.
REQ-018 FETCH, imem_rdy=1, stall=0: instr_ID<=imem_data, PC_ID<=pc, valid_ID<=1, pc<=pc+1.
REQ-019 FETCH, imem_rdy=1, stall=1: buffer<=imem_data and pc, buffer valid<=1, pc<=pc+1, state<=HOLD; IF/ID outputs unchanged.
REQ-020 FETCH, imem_rdy=0, stall=0: instr_ID<=NOP_INSTR, valid_ID<=0, PC_ID unchanged; pc unchanged.
REQ-021 FETCH, imem_rdy=0, stall=1: all registers unchanged.
REQ-022 HOLD: imem_re=0; while stall=1 nothing changes; first cycle with stall=0 loads instr_ID/PC_ID from buffer, valid_ID<=1, buffer valid<=0, state<=FETCH.
REQ-023 Latency: word accepted with imem_rdy in cycle N SHALL appear on instr_ID in cycle N+1 when stall=0.
REQ-024 pc+1 SHALL wrap 22'h3FFFFF to 22'h000000 with no other effect.
REQ-025 Priority SHALL be rst_n > branch_taken > hlt > stall > imem_rdy.
REQ-026 branch_taken=1 in any state: pc<=branch_addr, buffer valid<=0, instr_ID<=NOP_INSTR, valid_ID<=0, state<=FETCH; imem_data returned that cycle discarded; applies even if stall=1.
REQ-027 hlt=1 with branch_taken=0: state<=HALT, pc frozen, buffer valid<=0, instr_ID<=NOP_INSTR, valid_ID<=0 (squash instruction behind HALT).
REQ-028 HALT SHALL be left only by reset; branch_taken and hlt ignored while in HALT; imem_re=0.
REQ-029 imem_rdy SHALL be ignored whenever imem_re=0.

Reset
REQ-030 rst_n=0 at a rising edge: pc<=RESET_PC, state<=FETCH, instr_ID<=NOP_INSTR, PC_ID<=0, valid_ID<=0, buffer valid<=0; overrides all other inputs, including mid-HOLD or HALT.
REQ-031 imem_re SHALL be 0 in every cycle rst_n=0; fetch of RESET_PC begins the first cycle after release.

Verification
REQ-032 Reset release, imem_rdy=1 constantly, words 0x11,0x22,0x33 at addr 0,1,2 -> instr_ID 0x11/0x22/0x33, PC_ID 0/1/2, valid_ID=1 on cycles 1,2,3.
REQ-033 stall=1 in cycle imem_rdy returns 0x22 at pc=1, held 3 cycles -> instr_ID stays 0x11, state HOLD, imem_re=0; cycle after stall drops instr_ID=0x22, PC_ID=1, next fetch addr 2.
REQ-034 branch_taken=1, branch_addr=0x00100 while stall=1 and buffer valid -> next cycle instr_ID=0x3000_0000, valid_ID=0, imem_addr=0x00100, buffered word never emitted.
REQ-035 hlt=1 at pc=5 -> next cycle valid_ID=0, imem_re=0 forever; later branch_taken=1 has no effect; rst_n=0 restores fetch at RESET_PC.
REQ-036 pc=0x3FFFFF with imem_rdy=1 -> PC_ID=0x3FFFFF, next imem_addr=0x000000.
REQ-037 imem_rdy=0 for 2 cycles, stall=0 -> two bubbles (NOP, valid_ID=0), imem_addr stable; branch_taken and hlt asserted together -> branch wins, state FETCH.
